// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and
// default timing for a 12 MHz reference driving a 108 MHz pixel-clock PLL.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned DEF_RESET_CYCLES  = 12;    // 1 us RESETB pulse
  localparam int unsigned DEF_LOCK_TIMEOUT  = 1200;  // 100 us lock wait
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer with asynchronous active-low clear,
// for bringing asynchronous level signals (lock, keys, UART rx) into clk.
module sync_ff #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // NOTE: the chain is cleared on reset so the consumer sees a defined "not
  // asserted" value until real samples have propagated through every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL RESETB / system-reset sequencer on the always-valid reference clock.
// Define PLL_SEQ_RETRY_COUNT_EN to add the saturating retry_count debug output.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic [1:0] state_o
`ifdef PLL_SEQ_RETRY_COUNT_EN
  ,
  output logic [7:0] retry_count
`endif
);

  localparam int unsigned CNT_MAX = max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pll_resetb_q, sys_reset_n_q, ready_q;
  logic             lock_s;

  sync_ff #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock is tested first so it wins a tie with the timeout.
        if (lock_s)                                 state_d = STABLE;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) state_d = PLL_RST;
      end
      STABLE: begin
        if (!lock_s)                                 state_d = WAIT_LOCK;
        else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = PLL_RST;
      end
      default: state_d = PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they move on the same edge as
  // the state register and come straight from flops.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= PLL_RST;
      cnt_q         <= '0;
      pll_resetb_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_resetb_q  <= (state_d != PLL_RST);
      sys_reset_n_q <= (state_d == RUN);
      ready_q       <= (state_d == RUN);
    end
  end

`ifdef PLL_SEQ_RETRY_COUNT_EN
  logic [7:0] retry_q;

  // PLL_RST is only re-entered from a WAIT_LOCK timeout or a RUN lock loss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_q <= '0;
    end else if (state_q != PLL_RST && state_d == PLL_RST && retry_q != 8'hFF) begin
      retry_q <= retry_q + 8'd1;
    end
  end

  assign retry_count = retry_q;
`endif

  assign pll_resetb  = pll_resetb_q;
  assign sys_reset_n = sys_reset_n_q;
  assign ready       = ready_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer against a phase/elapsed-time
// reference model, with directed scenarios and randomized lock waveforms.
module tb_pll_reset_sequencer;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_resetb, sys_reset_n, ready;
  logic [1:0] state_o;
  logic [7:0] dut_retry;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .pll_resetb  (pll_resetb),
    .sys_reset_n (sys_reset_n),
    .ready       (ready),
    .state_o     (state_o)
`ifdef PLL_SEQ_RETRY_COUNT_EN
    ,
    .retry_count (dut_retry)
`endif
  );

`ifndef PLL_SEQ_RETRY_COUNT_EN
  assign dut_retry = 8'd0;
`endif

  logic [12:0] dut_vec;
  assign dut_vec = {pll_resetb, sys_reset_n, ready, state_o, dut_retry};

  // Reference model: phase 0=reset pulse, 1=waiting, 2=stabilising, 3=running.
  // Timing is expressed as edges elapsed since the phase was entered; the
  // synchronized lock seen at edge k is the pll_locked driven before edge k-SS.
  int   m_ph, m_edge, m_entry, m_retry;
  logic hist[$];

  function automatic logic [12:0] exp_vec();
    logic [7:0] r;
`ifdef PLL_SEQ_RETRY_COUNT_EN
    r = 8'(m_retry);
`else
    r = 8'd0;
`endif
    return {m_ph != 0, m_ph == 3, m_ph == 3, 2'(m_ph), r};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_edge = 0; m_entry = 0; m_retry = 0;
    hist.delete();
  endtask

  task automatic enter(input int ph);
    m_ph = ph;
    m_entry = m_edge;
  endtask

  task automatic model_edge(input logic lk);
    logic ls;
    int   age;
    m_edge++;
    ls = (hist.size() >= SS) ? hist[hist.size() - SS] : 1'b0;
    hist.push_back(lk);
    age = m_edge - m_entry;
    case (m_ph)
      0: if (age == RC) enter(1);
      1: if (ls) enter(2);
         else if (age == LT) begin enter(0); if (m_retry < 255) m_retry++; end
      2: if (!ls) enter(1);
         else if (age == SC) enter(3);
      default: if (!ls) begin enter(0); if (m_retry < 255) m_retry++; end
    endcase
  endtask

  task automatic tick(input logic lk);
    pll_locked = lk;
    @(posedge clk);
    model_edge(lk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pll_locked = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pll_locked = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== 13'd0) begin
        failures++;
        $display("FAIL reset_values[%0d] got=%b exp=%b", i, dut_vec, 13'd0);
      end
    end
  endtask

  task automatic test_lock_high();
    int rise_at;
    do_reset();
    rise_at = -1;
    for (int k = 1; k <= 16; k++) begin
      tick(1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL lock_high_cycle%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (rise_at < 0 && sys_reset_n === 1'b1) rise_at = k;
    end
    checks++;
    if (rise_at != RC + 1 + SC) begin
      failures++;
      $display("FAIL lock_high_latency got=%0d exp=%0d", rise_at, RC + 1 + SC);
    end
  endtask

  task automatic test_no_lock();
    int highs;
    do_reset();
    highs = 0;
    for (int k = 1; k <= 2 * (RC + LT) + 6; k++) begin
      tick(1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL no_lock_cycle%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (pll_resetb === 1'b1) highs++;
    end
    checks++;
    if (highs != 2 * LT + 3) begin
      failures++;
      $display("FAIL no_lock_resetb_high_cycles got=%0d exp=%0d", highs, 2 * LT + 3);
    end
`ifdef PLL_SEQ_RETRY_COUNT_EN
    checks++;
    if (dut_retry !== 8'd2) begin
      failures++;
      $display("FAIL no_lock_retry_count got=%0d exp=2", dut_retry);
    end
`endif
  endtask

  task automatic test_stable_glitch();
    int  run_at;
    logic pulsed;
    do_reset();
    run_at = -1;
    pulsed = 1'b0;
    // Lock low only before edge 9 reaches the FSM at edge 11, stable count 5.
    for (int k = 1; k <= 24; k++) begin
      tick(k != 9);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL stable_glitch_cycle%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (k >= RC && pll_resetb !== 1'b1) pulsed = 1'b1;
      if (run_at < 0 && ready === 1'b1) run_at = k;
    end
    checks++;
    if (run_at != 12 + SC || pulsed) begin
      failures++;
      $display("FAIL stable_glitch_run got=%0d pulse=%b exp=%0d pulse=0", run_at, pulsed, 12 + SC);
    end
  endtask

  task automatic test_run_loss();
    int n, lows;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1'b0);
      n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL run_loss_cycle%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (sys_reset_n === 1'b0) break;
    end
    checks++;
    if (n != SS + 1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL run_loss_delay got=%0d ready=%b exp=%0d ready=0", n, ready, SS + 1);
    end
    lows = (pll_resetb === 1'b0) ? 1 : 0;
    for (int k = 1; k <= 30; k++) begin
      tick(k > 2);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL relock_cycle%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (pll_resetb === 1'b0) lows++;
    end
    checks++;
    if (lows != RC || state_o !== 2'd3) begin
      failures++;
      $display("FAIL relock_result lows=%0d state=%0d exp lows=%0d state=3", lows, state_o, RC);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL async_pre_cycle%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 13'd0) begin
      failures++;
      $display("FAIL async_reset_values got=%b exp=%b", dut_vec, 13'd0);
    end
  endtask

  task automatic test_timeout_race();
    do_reset();
    // Synchronized lock first appears exactly on the timeout edge (edge RC+LT).
    for (int k = 1; k <= 30; k++) begin
      tick(k >= RC + LT - SS);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL race_cycle%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (k == RC + LT) begin
        checks++;
        if (state_o !== 2'd2 || dut_retry !== 8'd0) begin
          failures++;
          $display("FAIL race_lock_wins state=%0d retry=%0d exp state=2 retry=0", state_o, dut_retry);
        end
      end
    end
  endtask

  task automatic test_random();
    logic lk;
    int   hold;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      lk = 1'b0;
      hold = 0;
      for (int k = 1; k <= 150; k++) begin
        if (hold == 0) begin
          lk = ~lk;
          hold = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 30));
        end
        hold--;
        tick(lk);
        checks++;
        if (dut_vec !== exp_vec()) begin
          failures++;
          $display("FAIL random%0d_cycle%0d got=%b exp=%b", it, k, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_high();
    test_no_lock();
    test_stable_glitch();
    test_run_loss();
    test_async_reset();
    test_timeout_race();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
